// File: rtl/treino_ctrl.sv
// Epoch scheduler for the perceptron trainer: owns w0..w2 and drives the update datapath sample by sample.
// Optional per-epoch error counters are compiled in with `define TREINO_ERRCNT_EN.
module treino_ctrl #(
  parameter int TAM         = 16,
  parameter int NUM_SAMPLES = 4,
  parameter int MAX_EPOCHS  = 32,
  parameter int EW          = 8,
  localparam int SW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
  localparam int CW = (NUM_SAMPLES > 0) ? $clog2(NUM_SAMPLES + 1) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  input  logic [TAM-1:0] w0_init,
  input  logic [TAM-1:0] w1_init,
  input  logic [TAM-1:0] w2_init,
  output logic           step_req,
  output logic [SW-1:0]  sample_idx,
  input  logic           step_ack,
  input  logic           err,
  input  logic [TAM-1:0] w0_new,
  input  logic [TAM-1:0] w1_new,
  input  logic [TAM-1:0] w2_new,
  output logic [TAM-1:0] w0,
  output logic [TAM-1:0] w1,
  output logic [TAM-1:0] w2,
  output logic           busy,
  output logic           done,
  output logic           converged,
  output logic [EW-1:0]  epoch_count,
`ifdef TREINO_ERRCNT_EN
  output logic [CW-1:0]  err_count,
  output logic [CW-1:0]  last_err_count,
`endif
  output logic [2:0]     state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [SW-1:0] LAST_IDX  = SW'(NUM_SAMPLES - 1);
  localparam logic [EW-1:0] EPOCH_MAX = EW'(MAX_EPOCHS);

  // Handshake: step_req rises the cycle after ISSUE and stays high until a cycle
  // in which step_ack is sampled high; that cycle transfers w*_new/err, and
  // step_req is low on the following cycle. An ack with step_req low is ignored.

  logic [2:0]     state_q, state_d;
  logic           step_req_q, step_req_d;
  logic [SW-1:0]  sample_idx_q, sample_idx_d;
  logic [TAM-1:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic           converged_q, converged_d;
  logic           epoch_err_q, epoch_err_d;
  logic [EW-1:0]  epoch_count_q, epoch_count_d;
  logic [EW-1:0]  epoch_inc;
  logic           ack_take;
`ifdef TREINO_ERRCNT_EN
  logic [CW-1:0]  err_count_q, err_count_d;
  logic [CW-1:0]  last_err_count_q, last_err_count_d;
`endif

  assign epoch_inc = epoch_count_q + EW'(1);
  assign ack_take  = step_req_q && step_ack;

  always_comb begin
    state_d       = state_q;
    step_req_d    = step_req_q;
    sample_idx_d  = sample_idx_q;
    w0_d          = w0_q;
    w1_d          = w1_q;
    w2_d          = w2_q;
    converged_d   = converged_q;
    epoch_err_d   = epoch_err_q;
    epoch_count_d = epoch_count_q;
`ifdef TREINO_ERRCNT_EN
    err_count_d      = err_count_q;
    last_err_count_d = last_err_count_q;
`endif
    if (abort) begin
      // Weights and epoch_count are left untouched so an aborted run can be inspected.
      state_d     = S_IDLE;
      step_req_d  = 1'b0;
      converged_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d       = S_LOAD;
            epoch_count_d = '0;
            converged_d   = 1'b0;
            sample_idx_d  = '0;
            epoch_err_d   = 1'b0;
          end
        end
        S_LOAD: begin
          w0_d    = w0_init;
          w1_d    = w1_init;
          w2_d    = w2_init;
          state_d = S_ISSUE;
`ifdef TREINO_ERRCNT_EN
          err_count_d      = '0;
          last_err_count_d = '0;
`endif
        end
        S_ISSUE: begin
          step_req_d = 1'b1;
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          if (ack_take) begin
            w0_d        = w0_new;
            w1_d        = w1_new;
            w2_d        = w2_new;
            epoch_err_d = epoch_err_q | err;
            step_req_d  = 1'b0;
`ifdef TREINO_ERRCNT_EN
            if (err) err_count_d = err_count_q + CW'(1);
`endif
            if (sample_idx_q == LAST_IDX) begin
              state_d = S_CHECK;
            end else begin
              sample_idx_d = sample_idx_q + SW'(1);
              state_d      = S_ISSUE;
            end
          end
        end
        S_CHECK: begin
          epoch_count_d = epoch_inc;
`ifdef TREINO_ERRCNT_EN
          last_err_count_d = err_count_q;
`endif
          if (!epoch_err_q) begin
            state_d     = S_DONE;
            converged_d = 1'b1;
          end else if (epoch_inc == EPOCH_MAX) begin
            state_d     = S_DONE;
            converged_d = 1'b0;
          end else begin
            epoch_err_d  = 1'b0;
            sample_idx_d = '0;
            state_d      = S_ISSUE;
`ifdef TREINO_ERRCNT_EN
            err_count_d = '0;
`endif
          end
        end
        default: begin
          state_d    = S_IDLE;
          step_req_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      step_req_q    <= 1'b0;
      sample_idx_q  <= '0;
      w0_q          <= '0;
      w1_q          <= '0;
      w2_q          <= '0;
      converged_q   <= 1'b0;
      epoch_err_q   <= 1'b0;
      epoch_count_q <= '0;
`ifdef TREINO_ERRCNT_EN
      err_count_q      <= '0;
      last_err_count_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      step_req_q    <= step_req_d;
      sample_idx_q  <= sample_idx_d;
      w0_q          <= w0_d;
      w1_q          <= w1_d;
      w2_q          <= w2_d;
      converged_q   <= converged_d;
      epoch_err_q   <= epoch_err_d;
      epoch_count_q <= epoch_count_d;
`ifdef TREINO_ERRCNT_EN
      err_count_q      <= err_count_d;
      last_err_count_q <= last_err_count_d;
`endif
    end
  end

  assign step_req    = step_req_q;
  assign sample_idx  = sample_idx_q;
  assign w0          = w0_q;
  assign w1          = w1_q;
  assign w2          = w2_q;
  assign busy        = (state_q == S_LOAD) || (state_q == S_ISSUE) ||
                       (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done        = (state_q == S_DONE);
  assign converged   = converged_q;
  assign epoch_count = epoch_count_q;
  assign state_dbg   = state_q;
`ifdef TREINO_ERRCNT_EN
  assign err_count      = err_count_q;
  assign last_err_count = last_err_count_q;
`endif

endmodule

// File: tb/tb_treino_ctrl.sv
// Bench for treino_ctrl: a datapath responder model, a request/result scoreboard and directed epoch scenarios.
module tb_treino_ctrl;
  localparam int TAM = 16;
  localparam int NS  = 4;
  localparam int ME  = 3;
  localparam int EW  = 8;
  localparam int SW  = 2;
  localparam int CW  = 3;
  localparam int RW  = SW + 3 * TAM;
  localparam int DW  = 1 + EW + 3 * TAM;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;

  logic           clk = 1'b0;
  logic           reset, start, abort;
  logic [TAM-1:0] w0_init, w1_init, w2_init;
  logic           step_req, step_ack, err;
  logic [SW-1:0]  sample_idx;
  logic [TAM-1:0] w0_new, w1_new, w2_new, w0, w1, w2;
  logic           busy, done, converged;
  logic [EW-1:0]  epoch_count;
  logic [2:0]     state_dbg;
`ifdef TREINO_ERRCNT_EN
  logic [CW-1:0]  err_count, last_err_count;
`endif

  int checks = 0;
  int errors = 0;
  int mode = 0;
  int base = 0;
  int ack_n = 0;
  int req_cnt = 0;
  int acc_acks = 0;
  logic [RW-1:0] exp_q[$];
  logic [DW-1:0] exp_done_q[$];

  treino_ctrl #(.TAM(TAM), .NUM_SAMPLES(NS), .MAX_EPOCHS(ME), .EW(EW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .w0_init(w0_init), .w1_init(w1_init), .w2_init(w2_init),
    .step_req(step_req), .sample_idx(sample_idx), .step_ack(step_ack), .err(err),
    .w0_new(w0_new), .w1_new(w1_new), .w2_new(w2_new),
    .w0(w0), .w1(w1), .w2(w2),
    .busy(busy), .done(done), .converged(converged), .epoch_count(epoch_count),
`ifdef TREINO_ERRCNT_EN
    .err_count(err_count), .last_err_count(last_err_count),
`endif
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] req_w(input int k, input logic [TAM-1:0] a,
                                          input logic [TAM-1:0] b, input logic [TAM-1:0] c);
    logic [SW-1:0] idx;
    idx = SW'(k % NS);
    return {idx, a, b, c};
  endfunction

  // monitor / scoreboard: sampled 1 time unit after each rising edge
  initial begin
    logic last_req, last_done;
    logic [RW-1:0] e;
    logic [DW-1:0] d;
    last_req  = 1'b0;
    last_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (last_req && step_ack && !abort && !reset) acc_acks++;
      if (last_req && !step_req) chk("req_hold", 64'(step_ack | abort | reset), 64'(1));
      if (!last_req && step_req) begin
        req_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected: got request idx %0d, expected no request", sample_idx);
        end else begin
          e = exp_q.pop_front();
          chk("req", 64'({sample_idx, w0, w1, w2}), 64'(e));
        end
      end
      if (!last_done && done) begin
        if (exp_done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done with epoch_count %0d, expected none", epoch_count);
        end else begin
          d = exp_done_q.pop_front();
          chk("result", 64'({converged, epoch_count, w0, w1, w2}), 64'(d));
        end
      end
      last_req  = step_req;
      last_done = done;
    end
  end

  // datapath responder model
  initial begin
    int lat;
    int k;
    step_ack = 1'b0; err = 1'b0; abort = 1'b0;
    w0_new = '0; w1_new = '0; w2_new = '0;
    lat = -1;
    forever begin
      @(negedge clk);
      step_ack = 1'b0;
      abort    = 1'b0;
      err      = 1'b0;
      if (!step_req) begin
        lat = -1;
        if (mode == 3 && $urandom_range(0, 2) == 0) begin
          step_ack = 1'b1; err = 1'b1;
          w0_new = 16'hDEAD; w1_new = 16'hBEEF; w2_new = 16'hCAFE;
        end
      end else if (lat != -2) begin
        if (lat < 0) lat = $urandom_range(0, 5);
        if (lat == 0) begin
          k = ack_n - base;
          if (mode == 5) begin
            lat = -2;
          end else if (mode == 4 && k == 5) begin
            abort = 1'b1; step_ack = 1'b1; err = 1'b1;
            w0_new = 16'hBAD0; w1_new = 16'hBAD1; w2_new = 16'hBAD2;
            lat = -2;
          end else begin
            w0_new = w0; w1_new = w1; w2_new = w2;
            case (mode)
              1: begin
                err = (k == 2);
                if (k == 2) w1_new = 16'h3E00;
              end
              2, 4: begin err = 1'b1; w0_new = w0 + 16'd1; end
              3: begin err = (k == 0); w0_new = w0 + 16'd1; end
              default: err = 1'b0;
            endcase
            step_ack = 1'b1;
            ack_n++;
            lat = -1;
          end
        end else begin
          lat--;
        end
      end
    end
  end

  // driver tasks
  task automatic setup(input int m, input logic [TAM-1:0] a, input logic [TAM-1:0] b,
                       input logic [TAM-1:0] c);
    @(negedge clk);
    mode = m; base = ack_n;
    w0_init = a; w1_init = b; w2_init = c;
  endtask

  task automatic start_pulse;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    chk("done_timeout", 64'(done), 64'(1));
  endtask

  task automatic wait_reqs(input int target, input int budget);
    int n = 0;
    while (req_cnt < target && n < budget) begin @(negedge clk); n++; end
    chk("req_timeout", 64'(req_cnt >= target), 64'(1));
  endtask

  task automatic queues_empty(input string name);
    chk({name, "_req_q"}, 64'(exp_q.size()), 64'(0));
    chk({name, "_done_q"}, 64'(exp_done_q.size()), 64'(0));
  endtask

  // directed scenarios
  initial begin
    int r0, a0, n;
    reset = 1'b1; start = 1'b0;
    w0_init = '0; w1_init = '0; w2_init = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_state", 64'(state_dbg), 64'(S_IDLE));
    chk("rst_outs", 64'({step_req, busy, done, converged, sample_idx, epoch_count}), 64'(0));

    // reset held 2 cycles in the middle of WAIT
    setup(5, 16'h1111, 16'h2222, 16'h3333);
    exp_q.push_back(req_w(0, 16'h1111, 16'h2222, 16'h3333));
    r0 = req_cnt;
    start_pulse();
    wait_reqs(r0 + 1, 50);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("wait_rst_state", 64'(state_dbg), 64'(S_IDLE));
    chk("wait_rst_w", 64'({w0, w1, w2}), 64'(0));
    chk("wait_rst_outs", 64'({step_req, busy, done, sample_idx, epoch_count}), 64'(0));
    queues_empty("rst");

    // converge in one epoch
    setup(0, 16'h3C00, 16'h3C00, 16'h3C00);
    for (int k = 0; k < 4; k++) exp_q.push_back(req_w(k, 16'h3C00, 16'h3C00, 16'h3C00));
    exp_done_q.push_back({1'b1, 8'd1, 16'h3C00, 16'h3C00, 16'h3C00});
    start_pulse();
    wait_done(500);
    queues_empty("conv1");

    // converge in epoch 2: one error on sample 2 of epoch 1 updates w1
    setup(1, 16'h3C00, 16'h3C00, 16'h3C00);
    for (int k = 0; k < 8; k++)
      exp_q.push_back(req_w(k, 16'h3C00, (k >= 3) ? 16'h3E00 : 16'h3C00, 16'h3C00));
    exp_done_q.push_back({1'b1, 8'd2, 16'h3C00, 16'h3E00, 16'h3C00});
    r0 = req_cnt;
    start_pulse();
`ifdef TREINO_ERRCNT_EN
    wait_reqs(r0 + 5, 500);
    chk("last_err_count", 64'(last_err_count), 64'(1));
    chk("err_count_new_epoch", 64'(err_count), 64'(0));
`endif
    wait_done(1000);
    queues_empty("conv2");

    // epoch limit: every sample errs
    setup(2, 16'h1000, 16'h1100, 16'h1200);
    for (int k = 0; k < 12; k++) exp_q.push_back(req_w(k, 16'h1000 + 16'(k), 16'h1100, 16'h1200));
    exp_done_q.push_back({1'b0, 8'd3, 16'h100C, 16'h1100, 16'h1200});
    a0 = acc_acks;
    start_pulse();
    wait_done(1500);
    chk("limit_acks", 64'(acc_acks - a0), 64'(12));
    queues_empty("limit");

    // handshake: random latency, spurious acks, start pulses while busy
    setup(3, 16'h2000, 16'h2100, 16'h2200);
    for (int k = 0; k < 8; k++) exp_q.push_back(req_w(k, 16'h2000 + 16'(k), 16'h2100, 16'h2200));
    exp_done_q.push_back({1'b1, 8'd2, 16'h2008, 16'h2100, 16'h2200});
    start_pulse();
    n = 0;
    while (!done && n < 1500) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && $urandom_range(0, 3) == 0) start = 1'b1;
      n++;
    end
    start = 1'b0;
    chk("hs_done_timeout", 64'(done), 64'(1));
    repeat (5) @(negedge clk);
    chk("hs_done_hold", 64'({done, converged, epoch_count, w0}), 64'({1'b1, 1'b1, 8'd2, 16'h2008}));
    queues_empty("hs");

    // abort in WAIT of sample 1, epoch 2, then restart
    setup(4, 16'h3000, 16'h3100, 16'h3200);
    for (int k = 0; k < 6; k++) exp_q.push_back(req_w(k, 16'h3000 + 16'(k), 16'h3100, 16'h3200));
    r0 = req_cnt;
    a0 = acc_acks;
    start_pulse();
    wait_reqs(r0 + 6, 1000);
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    chk("abort_state", 64'(state_dbg), 64'(S_IDLE));
    chk("abort_flags", 64'({busy, done, converged, step_req}), 64'(0));
    chk("abort_hold", 64'({epoch_count, w0, w1, w2}), 64'({8'd1, 16'h3005, 16'h3100, 16'h3200}));
    chk("abort_acks", 64'(acc_acks - a0), 64'(5));
    setup(0, 16'h4000, 16'h4100, 16'h4200);
    for (int k = 0; k < 4; k++) exp_q.push_back(req_w(k, 16'h4000, 16'h4100, 16'h4200));
    exp_done_q.push_back({1'b1, 8'd1, 16'h4000, 16'h4100, 16'h4200});
    start_pulse();
    chk("restart_load", 64'({state_dbg, epoch_count}), 64'({S_LOAD, 8'd0}));
    wait_done(500);
    queues_empty("restart");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/treino_ctrl.md
Name: treino_ctrl

Overview:
- Epoch scheduler for the perceptron training datapath (half-precision, TAM-bit weights; 16'h3C00 = 1.0).
- Owns the working weight registers w0/w1/w2 and loads them from the initial values on start.
- Steps the shared single-sample update datapath through the NUM_SAMPLES training vectors with a req/ack handshake, and repeats epochs until an error-free epoch (converged) or MAX_EPOCHS is reached.
- Sits between the top-level training wrapper and the neuron/update datapath.

Parameters:
- TAM, 16, weight/data width in bits (IEEE half-precision).
- NUM_SAMPLES, 4, training vectors per epoch; must be >= 1.
- MAX_EPOCHS, 32, epoch limit; 1 <= MAX_EPOCHS <= 2^EW-1.
- EW, 8, width of the epoch counter.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin training; honoured only in IDLE or DONE.
- abort  in  1  synchronous abandon; return to IDLE.
- w0_init, w1_init, w2_init  in  TAM  initial weights, sampled in LOAD.
- step_req  out  1  request the datapath to process sample sample_idx with w0..w2.
- sample_idx  out  $clog2(NUM_SAMPLES) (min 1)  current sample index.
- step_ack  in  1  datapath finished; w*_new and err are valid this cycle.
- err  in  1  sample output differed from target (nonzero error).
- w0_new, w1_new, w2_new  in  TAM  updated weights from the datapath.
- w0, w1, w2  out  TAM  current working weights.
- busy  out  1  high in LOAD/ISSUE/WAIT/CHECK.
- done  out  1  level; high in DONE.
- converged  out  1  valid while done; 1 means the last epoch had no errors.
- epoch_count  out  EW  completed epochs.

Behaviour:
- Reset (sync): state=IDLE; all outputs 0, including the weights, sample_idx and epoch_count. Reset has priority over abort, which has priority over start.
- States: IDLE, LOAD, ISSUE, WAIT, CHECK, DONE.
- IDLE/DONE, start=1:
  - Go to LOAD; clear epoch_count, converged, done, sample_idx and epoch_err.
  - In DONE, all results hold until start.
- LOAD (1 cycle): w0..w2 <= w*_init; go to ISSUE.
- ISSUE (1 cycle): assert step_req; go to WAIT.
- WAIT:
  - step_req stays high until step_ack is sampled.
  - On the ack cycle: latch w*_new into w0..w2; epoch_err |= err; step_req deasserts next cycle.
  - If sample_idx == NUM_SAMPLES-1, go to CHECK; otherwise sample_idx++ and go to ISSUE.
  - Minimum per-sample cost is 2 cycles (ack in the first WAIT cycle).
- step_ack while step_req=0 is ignored; the weights are not touched.
- CHECK (1 cycle):
  - epoch_count++.
  - If !epoch_err: go to DONE with converged=1.
  - Else if the new epoch_count == MAX_EPOCHS: go to DONE with converged=0.
  - Else: clear epoch_err, sample_idx=0, go to ISSUE.
- The weights keep their last update across epochs. They are never reloaded except in LOAD.
- start while busy is ignored.
- abort in any state:
  - Next state IDLE; step_req, busy, done and converged go to 0.
  - Weights and epoch_count hold their values for debug.
  - An ack arriving in the abort cycle is discarded.
- epoch_count never wraps (bounded by MAX_EPOCHS).
- No floating-point arithmetic in this block; the weights pass through unchanged.

Optional Feature:
- Macro: TREINO_ERRCNT_EN.
- When defined:
  - Extra output err_count (width $clog2(NUM_SAMPLES+1)) counts the samples with err=1 in the epoch being run.
  - Extra output last_err_count, latched in CHECK, holds the error count of the last completed epoch.
  - Both are cleared on reset and in LOAD.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset: hold reset 2 cycles mid-WAIT -> next cycle IDLE, w0..w2=0, step_req=0, busy=0, done=0, epoch_count=0.
- Converge in one epoch:
  - Stimulus: w*_init=16'h3C00; model acks 1 cycle after req with err=0 and w*_new=16'h3C00.
  - Response: sample_idx sequence 0,1,2,3; done=1, converged=1, epoch_count=1, w0..w2=16'h3C00.
- Converge in epoch 2: model returns err=1 on sample 2 of epoch 1 with w1_new=16'h3E00, else err=0 -> done, converged=1, epoch_count=2, w1=16'h3E00 (held across the epoch boundary).
- Epoch limit: MAX_EPOCHS=3, err=1 always -> exactly 12 acks, done=1, converged=0, epoch_count=3.
- Handshake:
  - Stimulus: ack latency randomized 0..5 cycles; spurious step_ack pulses while step_req=0.
  - Response: step_req held until ack; spurious acks change no weight or index; start pulses while busy ignored.
- Abort/restart: abort during WAIT of sample 1 epoch 2 -> IDLE, done=0; a following start reloads w*_init and epoch_count=0. With TREINO_ERRCNT_EN: last_err_count=1 after the epoch-1 CHECK of the convergence test.
